// File: rtl/i2s_define.sv
// Shared I2S definitions: divider width, slot lengths, channel encoding and
// the clock generator state type.
package i2s_define;

   localparam int I2S_DIV_WIDTH = 16;
   localparam int I2S_SLOT_W16  = 16;
   localparam int I2S_SLOT_W32  = 32;

   localparam logic I2S_CHL_16 = 1'b0;
   localparam logic I2S_CHL_32 = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } i2s_clkgen_state_e;

   // Slot length in SCK periods for a channel-length select value.
   function automatic logic [5:0] i2s_slot_len(input logic chl,
                                               input logic [5:0] w16,
                                               input logic [5:0] w32);
      logic [5:0] len_s;
      case (chl)
         I2S_CHL_32: len_s = w32;
         I2S_CHL_16: len_s = w16;
         default:    len_s = w16;
      endcase
      return len_s;
   endfunction

endpackage

// File: rtl/i2s_clkdiv.sv
// SCK divider: toggles sck every (div_i+1) clk_i cycles while enabled and
// emits registered one-cycle strobes coincident with each sck transition.
// tick_o flags (combinationally) that the current edge toggles sck.
module i2s_clkdiv #(
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic                 load_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   output logic                 sck_o,
   output logic                 rise_o,
   output logic                 fall_o,
   output logic                 tick_o
);

   logic [DIV_WIDTH-1:0] div_cnt_r;
   logic                 sck_r;
   logic                 rise_r;
   logic                 fall_r;

   assign tick_o = en_i & ~load_i & (div_cnt_r == div_i);
   assign sck_o  = sck_r;
   assign rise_o = rise_r;
   assign fall_o = fall_r;

   // Half-period counter, sck toggle and edge strobes; idle/load park sck low.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_cnt_r <= {DIV_WIDTH{1'b0}};
         sck_r     <= 1'b0;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
      end else if (load_i) begin
         div_cnt_r <= {DIV_WIDTH{1'b0}};
         sck_r     <= 1'b0;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
      end else if (en_i) begin
         if (tick_o) begin
            div_cnt_r <= {DIV_WIDTH{1'b0}};
            sck_r     <= ~sck_r;
            rise_r    <= ~sck_r;
            fall_r    <= sck_r;
         end else begin
            div_cnt_r <= div_cnt_r + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            rise_r    <= 1'b0;
            fall_r    <= 1'b0;
         end
      end else begin
         div_cnt_r <= {DIV_WIDTH{1'b0}};
         sck_r     <= 1'b0;
         rise_r    <= 1'b0;
         fall_r    <= 1'b0;
      end
   end

endmodule

// File: rtl/i2s_clkgen.sv
// I2S master clock generator: FSM, slot bit counter, word select and
// configuration latching on top of the i2s_clkdiv SCK divider.
module i2s_clkgen
   import i2s_define::*;
#(
   parameter int DIV_WIDTH = I2S_DIV_WIDTH,
   parameter int SLOT_W16  = I2S_SLOT_W16,
   parameter int SLOT_W32  = I2S_SLOT_W32
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 en_i,
   input  logic [DIV_WIDTH-1:0] div_i,
   input  logic                 chl_i,
   output logic                 busy_o,
   output logic                 i2s_sck_o,
   output logic                 i2s_ws_o,
   output logic                 sck_rise_o,
   output logic                 sck_fall_o,
   output logic                 frame_start_o
);

   i2s_clkgen_state_e    state_r, state_nx_s;
   logic [DIV_WIDTH-1:0] div_q_r, div_q_nx_s;
   logic [5:0]           slot_q_r, slot_q_nx_s;
   logic [4:0]           bit_cnt_r, bit_cnt_nx_s;
   logic                 ws_r, ws_nx_s;
   logic                 busy_r, busy_nx_s;
   logic                 frame_start_r, frame_start_nx_s;
   logic                 load_s;
   logic                 sck_s;
   logic                 tick_s;
   logic                 fall_evt_s;
   logic                 slot_end_s;
   logic [5:0]           slot_sel_s;

   assign slot_sel_s = i2s_slot_len(chl_i, 6'(SLOT_W16), 6'(SLOT_W32));
   assign fall_evt_s = tick_s & sck_s;
   assign slot_end_s = ({1'b0, bit_cnt_r} == (slot_q_r - 6'd1));

   i2s_clkdiv #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_clkdiv (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .en_i   (state_r == RUN),
      .load_i (load_s),
      .div_i  (div_q_r),
      .sck_o  (sck_s),
      .rise_o (sck_rise_o),
      .fall_o (sck_fall_o),
      .tick_o (tick_s)
   );

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next state, slot counting, ws and config latching at frame boundaries.
   always_comb begin
      state_nx_s       = state_r;
      div_q_nx_s       = div_q_r;
      slot_q_nx_s      = slot_q_r;
      bit_cnt_nx_s     = bit_cnt_r;
      ws_nx_s          = ws_r;
      busy_nx_s        = busy_r;
      frame_start_nx_s = 1'b0;
      load_s           = 1'b0;
      case (state_r)
         IDLE: begin
            busy_nx_s    = 1'b0;
            ws_nx_s      = 1'b0;
            bit_cnt_nx_s = 5'd0;
            if (en_i) begin
               div_q_nx_s       = div_i;
               slot_q_nx_s      = slot_sel_s;
               state_nx_s       = RUN;
               busy_nx_s        = 1'b1;
               frame_start_nx_s = 1'b1;
               load_s           = 1'b1;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            busy_nx_s = 1'b1;
            if (fall_evt_s) begin
               if (slot_end_s) begin
                  bit_cnt_nx_s = 5'd0;
                  ws_nx_s      = ~ws_r;
                  if (ws_r) begin
                     // Frame boundary: continue with fresh config or stop cleanly.
                     if (en_i) begin
                        div_q_nx_s       = div_i;
                        slot_q_nx_s      = slot_sel_s;
                        frame_start_nx_s = 1'b1;
                     end else begin
                        state_nx_s = IDLE;
                        busy_nx_s  = 1'b0;
                        ws_nx_s    = 1'b0;
                     end
                  end else begin
                     ws_nx_s = 1'b1;
                  end
               end else begin
                  bit_cnt_nx_s = bit_cnt_r + 5'd1;
               end
            end else begin
               bit_cnt_nx_s = bit_cnt_r;
            end
         end
         default: begin
            state_nx_s   = IDLE;
            busy_nx_s    = 1'b0;
            ws_nx_s      = 1'b0;
            bit_cnt_nx_s = 5'd0;
         end
      endcase
   end

   // Registered datapath and outputs.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         div_q_r       <= {DIV_WIDTH{1'b0}};
         slot_q_r      <= 6'd0;
         bit_cnt_r     <= 5'd0;
         ws_r          <= 1'b0;
         busy_r        <= 1'b0;
         frame_start_r <= 1'b0;
      end else begin
         div_q_r       <= div_q_nx_s;
         slot_q_r      <= slot_q_nx_s;
         bit_cnt_r     <= bit_cnt_nx_s;
         ws_r          <= ws_nx_s;
         busy_r        <= busy_nx_s;
         frame_start_r <= frame_start_nx_s;
      end
   end

   assign busy_o        = busy_r;
   assign i2s_sck_o     = sck_s;
   assign i2s_ws_o      = ws_r;
   assign frame_start_o = frame_start_r;

endmodule

// File: tb/tb_i2s_clkgen.sv
// Scoreboard bench for i2s_clkgen: stimulus pushes expected events
// (frame_start pulses, ws rises, busy falls) with their cycle and the number
// of sck rises seen since the last frame start; a monitor pops and compares.
module tb_i2s_clkgen;

   logic        clk = 1'b0;
   logic        rst_i = 1'b1;
   logic        en_i = 1'b0;
   logic [15:0] div_i = 16'd0;
   logic        chl_i = 1'b0;
   logic        busy_o, i2s_sck_o, i2s_ws_o, sck_rise_o, sck_fall_o, frame_start_o;

   typedef struct {
      int kind;   // 0 frame_start, 1 ws rise, 2 busy fall
      int cyc;
      int rises;
   } exp_t;

   exp_t exp_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   int   rc = 0;
   int   stray = 0;
   logic prev_busy = 1'b0;
   logic prev_ws = 1'b0;
   string kname[3] = '{"frame_start", "ws_rise", "busy_fall"};

   i2s_clkgen dut (
      .clk_i         (clk),
      .rst_i         (rst_i),
      .en_i          (en_i),
      .div_i         (div_i),
      .chl_i         (chl_i),
      .busy_o        (busy_o),
      .i2s_sck_o     (i2s_sck_o),
      .i2s_ws_o      (i2s_ws_o),
      .sck_rise_o    (sck_rise_o),
      .sck_fall_o    (sck_fall_o),
      .frame_start_o (frame_start_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic push(input int kind, input int c, input int r);
      exp_t e;
      e.kind = kind; e.cyc = c; e.rises = r;
      exp_q.push_back(e);
   endtask

   // Pop the next expected event and compare it with what the DUT just showed.
   task automatic observe(input int kind);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({"unexpected_", kname[kind]}, cyc, -1);
      end else begin
         e = exp_q.pop_front();
         chk("event_kind", kind, e.kind);
         chk({kname[e.kind], "_cycle"}, cyc, e.cyc);
         chk({kname[e.kind], "_rises"}, rc, e.rises);
         if (kind != 1) begin
            chk({kname[kind], "_sck"}, int'(i2s_sck_o), 0);
            chk({kname[kind], "_ws"}, int'(i2s_ws_o), 0);
         end
         if (kind != 1) rc = 0;
      end
   endtask

   // Monitor: samples 1 time unit after each rising edge.
   always @(posedge clk) begin
      #1;
      if (rst_i) begin
         rc = 0;
         prev_busy = 1'b0;
         prev_ws = 1'b0;
      end else begin
         if (sck_rise_o) rc++;
         if ((sck_rise_o && sck_fall_o) ||
             (!busy_o && !prev_busy &&
              (sck_rise_o || sck_fall_o || frame_start_o || i2s_sck_o || i2s_ws_o)))
            stray++;
         if (frame_start_o) observe(0);
         if (i2s_ws_o && !prev_ws) observe(1);
         if (!busy_o && prev_busy) observe(2);
         prev_busy = busy_o;
         prev_ws = i2s_ws_o;
      end
   end

   task automatic wait_cyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic start_run(input int div, input int chl, output int s);
      div_i = div[15:0];
      chl_i = chl[0];
      en_i = 1'b1;
      s = cyc + 1;
      push(0, s, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy_o), 0);
      chk({tag, "_sck"}, int'(i2s_sck_o), 0);
      chk({tag, "_ws"}, int'(i2s_ws_o), 0);
      chk({tag, "_rise"}, int'(sck_rise_o), 0);
      chk({tag, "_fall"}, int'(sck_fall_o), 0);
      chk({tag, "_fstart"}, int'(frame_start_o), 0);
   endtask

   initial begin
      int s;
      int guard;

      // Reset state.
      @(negedge clk); @(negedge clk);
      chk_all_zero("reset");
      rst_i = 1'b0;
      @(negedge clk);

      // div=1, 16-bit slots: SCK 4 clk, ws half 64, frame 128; en drops mid-left.
      start_run(1, 0, s);
      @(negedge clk);
      chk("busy_after_en", int'(busy_o), 1);
      push(1, s + 64, 16);
      push(0, s + 128, 32);
      push(1, s + 192, 16);
      push(2, s + 256, 32);
      wait_cyc(s + 150); en_i = 1'b0;
      wait_cyc(s + 262);

      // div=0, 32-bit slots: SCK 2 clk, ws half 64, frame 128.
      start_run(0, 1, s);
      push(1, s + 64, 32);
      push(0, s + 128, 64);
      push(1, s + 192, 32);
      push(2, s + 256, 64);
      wait_cyc(s + 140); en_i = 1'b0;
      wait_cyc(s + 262);

      // Mid-frame config change only takes effect at the next frame.
      start_run(1, 0, s);
      wait_cyc(s + 30); div_i = 16'd3; chl_i = 1'b1;
      push(1, s + 64, 16);
      push(0, s + 128, 32);
      push(1, s + 384, 32);
      push(2, s + 640, 64);
      wait_cyc(s + 400); en_i = 1'b0;
      wait_cyc(s + 646);

      // Async reset mid-right-slot, then restart with a one-frame run.
      start_run(1, 0, s);
      push(1, s + 64, 16);
      wait_cyc(s + 80);
      @(posedge clk); #2;
      rst_i = 1'b1;
      #1;
      chk_all_zero("async_rst");
      @(negedge clk); @(negedge clk);
      rst_i = 1'b0;
      s = cyc + 1;
      push(0, s, 0);
      push(1, s + 64, 16);
      push(2, s + 128, 32);
      @(negedge clk); en_i = 1'b0;
      wait_cyc(s + 134);

      // One-cycle en pulse from IDLE gives exactly one frame.
      start_run(1, 0, s);
      push(1, s + 64, 16);
      push(2, s + 128, 32);
      @(negedge clk); en_i = 1'b0;
      wait_cyc(s + 140);

      guard = 0;
      while (exp_q.size() != 0 && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      chk("queue_drained", exp_q.size(), 0);
      chk("stray_strobes", stray, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
